// File: rtl/tapper_pkg.sv
// Shared constants for the tapper game video path and a span test used by the sprite compositor.
package tapper_pkg;

    localparam int unsigned VGA_WIDTH          = 640;
    localparam int unsigned VGA_HEIGHT         = 480;
    localparam int unsigned PIXEL_VIRTUAL_SIZE = 4;

    localparam int unsigned ROW1 = 90;
    localparam int unsigned ROW2 = 186;
    localparam int unsigned ROW3 = 282;
    localparam int unsigned ROW4 = 378;

    localparam logic [23:0] BARTENDER = 24'h7F2B0A;
    localparam logic [23:0] CUSTOMER  = 24'h00FF00;

    // Evaluated at 32 bits so start + len can never wrap back onto low coordinates.
    function automatic logic in_span(input logic [31:0] pos, input logic [31:0] start,
                                     input logic [31:0] len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/sprite_hit_cmp.sv
// Per-slot rectangle bounds comparators: one hit bit per sprite for the current pixel.
module sprite_hit_cmp
    import tapper_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 6,
    parameter int unsigned SPRITE_W    = 20,
    parameter int unsigned SPRITE_H    = 20,
    parameter int unsigned COORD_W     = 10
) (
    input  logic [COORD_W-1:0]                  x,
    input  logic [COORD_W-1:0]                  y,
    input  logic [NUM_SPRITES-1:0][COORD_W-1:0] sx,
    input  logic [NUM_SPRITES-1:0][COORD_W-1:0] sy,
    input  logic [NUM_SPRITES-1:0]              en,
    output logic [NUM_SPRITES-1:0]              hit
);

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
        assign hit[i] = en[i]
                     && in_span(32'(x), 32'(sx[i]), SPRITE_W)
                     && in_span(32'(y), 32'(sy[i]), SPRITE_H);
    end

endmodule

// File: rtl/sprite_overlay_engine.sv
// Double-buffered sprite compositor feeding the VGA frame-buffer write port, 2-cycle pipeline.
// Optional collision accumulation is enabled by defining SPRITE_COLLISION_EN.
module sprite_overlay_engine
    import tapper_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 6,
    parameter int unsigned SPRITE_W    = 20,
    parameter int unsigned SPRITE_H    = 20,
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned VIRT_W      = 160,
    parameter int unsigned PIX_SHIFT   = 2,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned COLOR_W     = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   active_pixels,
    input  logic                   frame_done,
    input  logic [COORD_W-1:0]     x,
    input  logic [COORD_W-1:0]     y,
    input  logic                   upd_valid,
    output logic                   upd_ready,
    input  logic [3:0]             upd_idx,
    input  logic [COORD_W-1:0]     upd_x,
    input  logic [COORD_W-1:0]     upd_y,
    input  logic [COLOR_W-1:0]     upd_color,
    input  logic                   upd_en,
    output logic                   bad_idx,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [COLOR_W-1:0]     wr_data,
    output logic                   wr_en,
    output logic [NUM_SPRITES-1:0] coll_mask
);

    logic [NUM_SPRITES-1:0][COORD_W-1:0] sh_x, sh_y, lv_x, lv_y;
    logic [NUM_SPRITES-1:0][COLOR_W-1:0] sh_c, lv_c, s1_c;
    logic [NUM_SPRITES-1:0]              sh_en, lv_en, hit, s1_hit;

    logic               upd_take, idx_ok;
    logic [COORD_W-1:0] s1_x, s1_y;
    logic               s1_act, s1_any;
    logic [COLOR_W-1:0] win_c;
    logic [31:0]        addr_full;

    assign upd_ready = !frame_done;
    assign upd_take  = upd_valid && upd_ready;
    assign idx_ok    = 32'(upd_idx) < NUM_SPRITES;

    // Shadow slots take game writes; live slots change only at frame_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_x    <= '0;
            sh_y    <= '0;
            sh_c    <= '0;
            sh_en   <= '0;
            lv_x    <= '0;
            lv_y    <= '0;
            lv_c    <= '0;
            lv_en   <= '0;
            bad_idx <= 1'b0;
        end else begin
            bad_idx <= upd_take && !idx_ok;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (upd_take && upd_idx == 4'(i)) begin
                    sh_x[i]  <= upd_x;
                    sh_y[i]  <= upd_y;
                    sh_c[i]  <= upd_color;
                    sh_en[i] <= upd_en;
                end
            end
            if (frame_done) begin
                lv_x  <= sh_x;
                lv_y  <= sh_y;
                lv_c  <= sh_c;
                lv_en <= sh_en;
            end
        end
    end

    sprite_hit_cmp #(
        .NUM_SPRITES (NUM_SPRITES),
        .SPRITE_W    (SPRITE_W),
        .SPRITE_H    (SPRITE_H),
        .COORD_W     (COORD_W)
    ) u_hit_cmp (
        .x   (x),
        .y   (y),
        .sx  (lv_x),
        .sy  (lv_y),
        .en  (lv_en),
        .hit (hit)
    );

    // Colours are captured with the hits so a commit-cycle pixel stays on the old live set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_x   <= '0;
            s1_y   <= '0;
            s1_act <= 1'b0;
            s1_hit <= '0;
            s1_c   <= '0;
        end else begin
            s1_x   <= x;
            s1_y   <= y;
            s1_act <= active_pixels;
            s1_hit <= hit;
            s1_c   <= lv_c;
        end
    end

    always_comb begin
        win_c = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (s1_hit[i]) win_c = s1_c[i];
        end
        s1_any    = |s1_hit;
        addr_full = 32'(s1_y >> PIX_SHIFT) * 32'(VIRT_W) + 32'(s1_x >> PIX_SHIFT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= s1_act && s1_any;
            wr_addr <= addr_full[ADDR_W-1:0];
            if (s1_act && s1_any) wr_data <= win_c;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [NUM_SPRITES-1:0] accum, cur_coll;
    logic                   multi;

    // Clearing the lowest set bit leaves something only when two or more slots hit.
    assign multi    = |(s1_hit & (s1_hit - NUM_SPRITES'(1)));
    assign cur_coll = (s1_act && multi) ? s1_hit : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accum     <= '0;
            coll_mask <= '0;
        end else if (frame_done) begin
            coll_mask <= accum | cur_coll;
            accum     <= '0;
        end else begin
            accum <= accum | cur_coll;
        end
    end
`else
    assign coll_mask = '0;
`endif

endmodule

// File: tb/tb_sprite_overlay_engine.sv
// Directed bench for sprite_overlay_engine: frame-level reference model plus literal spot checks.
module tb_sprite_overlay_engine;
    import tapper_pkg::*;

    localparam int NS = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        active_pixels = 1'b0;
    logic        frame_done = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [3:0]  upd_idx = '0;
    logic [9:0]  upd_x = '0;
    logic [9:0]  upd_y = '0;
    logic [23:0] upd_color = '0;
    logic        upd_en = 1'b0;
    logic        bad_idx;
    logic [14:0] wr_addr;
    logic [23:0] wr_data;
    logic        wr_en;
    logic [NS-1:0] coll_mask;

    always #5 clk = ~clk;

    sprite_overlay_engine u_dut (
        .clk           (clk),
        .rst           (rst),
        .active_pixels (active_pixels),
        .frame_done    (frame_done),
        .x             (x),
        .y             (y),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_idx       (upd_idx),
        .upd_x         (upd_x),
        .upd_y         (upd_y),
        .upd_color     (upd_color),
        .upd_en        (upd_en),
        .bad_idx       (bad_idx),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .coll_mask     (coll_mask)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sprite tables as plain arrays, outputs delayed by two clocks.
    int sh_x[NS] = '{default: 0};
    int sh_y[NS] = '{default: 0};
    int sh_c[NS] = '{default: 0};
    bit sh_en[NS] = '{default: 0};
    int lv_x[NS] = '{default: 0};
    int lv_y[NS] = '{default: 0};
    int lv_c[NS] = '{default: 0};
    bit lv_en[NS] = '{default: 0};

    bit          p_act = 0;
    bit [NS-1:0] p_hits = '0;
    int          p_col = 0;
    int          p_addr = 0;
    bit          e_en = 0;
    int          e_addr = 0;
    int          e_data = 0;
    bit          e_bad = 0;
    bit [NS-1:0] e_coll = '0;
    bit [NS-1:0] acc = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NS; s++) begin
                sh_x[s] = 0; sh_y[s] = 0; sh_c[s] = 0; sh_en[s] = 0;
                lv_x[s] = 0; lv_y[s] = 0; lv_c[s] = 0; lv_en[s] = 0;
            end
            p_act = 0; p_hits = '0; p_col = 0; p_addr = 0;
            e_en = 0; e_addr = 0; e_data = 0; e_bad = 0; e_coll = '0; acc = '0;
        end else begin
            int px, py, ui;
            bit [NS-1:0] cur;
            e_en = p_act && (p_hits != '0);
            if (e_en) e_data = p_col;
            e_addr = p_addr;
            cur = (p_act && $countones(p_hits) >= 2) ? p_hits : '0;
`ifdef SPRITE_COLLISION_EN
            if (frame_done) begin
                e_coll = acc | cur;
                acc = '0;
            end else begin
                acc = acc | cur;
            end
`else
            e_coll = '0;
            acc = '0;
`endif
            px = int'(x);
            py = int'(y);
            p_act = active_pixels;
            p_hits = '0;
            p_col = 0;
            for (int s = 0; s < NS; s++) begin
                if (lv_en[s] && px >= lv_x[s] && px < lv_x[s] + 20
                    && py >= lv_y[s] && py < lv_y[s] + 20) p_hits[s] = 1'b1;
            end
            for (int s = NS - 1; s >= 0; s--) begin
                if (p_hits[s]) p_col = lv_c[s];
            end
            p_addr = ((py / 4) * 160 + px / 4) % 32768;
            ui = int'(upd_idx);
            e_bad = upd_valid && !frame_done && ui >= NS;
            if (upd_valid && !frame_done && ui < NS) begin
                sh_x[ui] = int'(upd_x);
                sh_y[ui] = int'(upd_y);
                sh_c[ui] = int'(upd_color);
                sh_en[ui] = upd_en;
            end
            if (frame_done) begin
                lv_x = sh_x; lv_y = sh_y; lv_c = sh_c; lv_en = sh_en;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("wr_en", 32'(wr_en), 32'(e_en));
            chk("wr_data", 32'(wr_data), 32'(e_data));
            if (e_en) chk("wr_addr", 32'(wr_addr), 32'(e_addr));
            chk("bad_idx", 32'(bad_idx), 32'(e_bad));
            chk("coll_mask", 32'(coll_mask), 32'(e_coll));
            chk("upd_ready", 32'(upd_ready), 32'(!frame_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input int idx, input int ux, input int uy, input int col,
                             input bit en);
        upd_valid = 1'b1;
        upd_idx = 4'(idx);
        upd_x = 10'(ux);
        upd_y = 10'(uy);
        upd_color = 24'(col);
        upd_en = en;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    // Leaves the pixel's result on the outputs when it returns.
    task automatic probe(input int px, input int py);
        active_pixels = 1'b1;
        x = 10'(px);
        y = 10'(py);
        tick();
        active_pixels = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        chk("reset wr_en", 32'(wr_en), 0);
        chk("reset wr_addr", 32'(wr_addr), 0);
        chk("reset wr_data", 32'(wr_data), 0);
        chk("reset bad_idx", 32'(bad_idx), 0);
        chk("reset coll_mask", 32'(coll_mask), 0);
        chk_on = 1'b1;
        rst = 1'b1;
        tick();

        // Empty sprite set: sampled rows across the whole frame must never write.
        active_pixels = 1'b1;
        for (int row = 0; row < 480; row += 16) begin
            for (int col = 0; col < 640; col++) begin
                x = 10'(col);
                y = 10'(row);
                tick();
            end
        end
        active_pixels = 1'b0;
        tick();
        tick();
        chk("empty frame wr_en", 32'(wr_en), 0);
        frame_pulse();

        do_update(0, 512, ROW1, BARTENDER, 1'b1);
        frame_pulse();
        probe(512, 90);
        chk("slot0 hit wr_en", 32'(wr_en), 1);
        chk("slot0 hit wr_addr", 32'(wr_addr), 3648);
        chk("slot0 hit wr_data", 32'(wr_data), 32'h7F2B0A);
        probe(531, 109);
        chk("slot0 corner wr_en", 32'(wr_en), 1);
        probe(532, 90);
        chk("slot0 right edge wr_en", 32'(wr_en), 0);
        chk("wr_data hold", 32'(wr_data), 32'h7F2B0A);
        probe(512, 110);
        chk("slot0 bottom edge wr_en", 32'(wr_en), 0);

        do_update(1, 100, 100, CUSTOMER, 1'b1);
        do_update(3, 100, 100, 32'h0000FF, 1'b1);
        frame_pulse();
        probe(105, 105);
        chk("priority wr_data", 32'(wr_data), 32'h00FF00);
        chk("priority wr_addr", 32'(wr_addr), 4186);
        do_update(1, 100, 100, CUSTOMER, 1'b0);
        frame_pulse();
        probe(105, 105);
        chk("slot3 alone wr_data", 32'(wr_data), 32'h0000FF);

        do_update(2, 300, 300, 32'h123456, 1'b1);
        probe(305, 305);
        chk("pre-commit wr_en", 32'(wr_en), 0);
        frame_pulse();
        probe(305, 305);
        chk("post-commit wr_en", 32'(wr_en), 1);
        chk("post-commit wr_data", 32'(wr_data), 32'h123456);

        upd_valid = 1'b1;
        upd_idx = 4'd4;
        upd_x = 10'd400;
        upd_y = 10'd400;
        upd_color = 24'hFFFFFF;
        upd_en = 1'b1;
        frame_done = 1'b1;
        #1;
        chk("upd_ready in commit", 32'(upd_ready), 0);
        tick();
        upd_valid = 1'b0;
        frame_done = 1'b0;
        frame_pulse();
        probe(405, 405);
        chk("refused update wr_en", 32'(wr_en), 0);

        do_update(15, 0, 0, 32'hFFFFFF, 1'b1);
        chk("bad_idx pulse", 32'(bad_idx), 1);
        tick();
        chk("bad_idx clears", 32'(bad_idx), 0);
        frame_pulse();
        probe(512, 90);
        chk("after bad idx wr_data", 32'(wr_data), 32'h7F2B0A);

        do_update(5, 1015, 0, 32'hABCDEF, 1'b1);
        frame_pulse();
        active_pixels = 1'b1;
        for (int yy = 0; yy < 5; yy++) begin
            for (int xx = 0; xx < 5; xx++) begin
                x = 10'(xx);
                y = 10'(yy);
                tick();
            end
        end
        active_pixels = 1'b0;
        probe(0, 0);
        chk("no wrap wr_en", 32'(wr_en), 0);
        probe(1020, 5);
        chk("far right wr_en", 32'(wr_en), 1);
        chk("far right wr_data", 32'(wr_data), 32'hABCDEF);
        chk("far right wr_addr", 32'(wr_addr), 415);

        do_update(1, 520, 95, CUSTOMER, 1'b1);
        frame_pulse();
        probe(525, 100);
        chk("overlap wr_data", 32'(wr_data), 32'h7F2B0A);
        frame_pulse();
`ifdef SPRITE_COLLISION_EN
        chk("coll_mask overlap", 32'(coll_mask), 32'h3);
`else
        chk("coll_mask disabled", 32'(coll_mask), 0);
`endif
        frame_pulse();
        chk("coll_mask clean frame", 32'(coll_mask), 0);

        active_pixels = 1'b1;
        x = 10'd512;
        y = 10'd90;
        tick();
        rst = 1'b0;
        #1;
        chk("async reset wr_en", 32'(wr_en), 0);
        chk("async reset wr_data", 32'(wr_data), 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("post reset wr_en", 32'(wr_en), 0);
        active_pixels = 1'b0;
        do_update(0, 512, ROW1, BARTENDER, 1'b1);
        frame_pulse();
        probe(515, 95);
        chk("recovered wr_en", 32'(wr_en), 1);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
